// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer with a double-buffered frame for the LED/button matrix column driver.
// Define SCAN_BLANK_EN to insert BLANK all-off cycles between rows; otherwise rows run back-to-back.
module matrix_scan_ctrl #(
  parameter int unsigned ROW       = 4,
  parameter int unsigned COL       = 4,
  parameter int unsigned PIXEL     = ROW * COL,
  parameter int unsigned BIT_COUNT = 2,
  parameter int unsigned DWELL     = 1000,
  parameter int unsigned BLANK     = 8,
  parameter int unsigned TMR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PIXEL-1:0]     frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [PIXEL-1:0]     display_matrix,
  output logic [BIT_COUNT-1:0] count,
  output logic [ROW-1:0]       row_n,
  output logic                 blank,
  output logic                 frame_start
);

  localparam int unsigned TmrSpan = (DWELL > BLANK) ? DWELL : BLANK;

  // Elaboration-time sanity checks on the parameter set.
  if ($clog2(ROW) > BIT_COUNT) begin : g_bad_count
    $error("BIT_COUNT too narrow for ROW");
  end
  if ($clog2(TmrSpan) > TMR_W) begin : g_bad_timer
    $error("TMR_W too narrow for DWELL/BLANK");
  end
  if (DWELL < 1 || BLANK < 1) begin : g_bad_dwell
    $error("DWELL and BLANK must be at least 1");
  end
  if (PIXEL != ROW * COL) begin : g_bad_pixel
    $error("PIXEL must equal ROW*COL");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] StBlank = 2'd2;
  localparam logic [TMR_W-1:0] BlankLast = TMR_W'(BLANK - 1);
`endif

  localparam logic [TMR_W-1:0]     DwellLast = TMR_W'(DWELL - 1);
  localparam logic [BIT_COUNT-1:0] RowLast   = BIT_COUNT'(ROW - 1);

  logic [1:0]           state_q, state_d;
  logic [BIT_COUNT-1:0] count_q, count_d, count_inc;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 wrap;
  logic                 boundary;

  logic [ROW-1:0]       row_n_q, row_n_d;
  logic                 blank_q, blank_d;
  logic                 frame_start_q;

  logic [PIXEL-1:0]     shadow_q, shadow_d;
  logic [PIXEL-1:0]     display_q, display_d;
  logic                 full_q, full_d;
  logic                 capture;

  // Explicit wrap so non-power-of-two ROW works.
  assign wrap      = (count_q == RowLast);
  assign count_inc = wrap ? '0 : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q + 1'b1;
    boundary = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      count_d = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StDrive;
          count_d  = '0;
          timer_d  = '0;
          boundary = 1'b1;
        end
        StDrive: begin
          if (timer_q == DwellLast) begin
            timer_d = '0;
`ifdef SCAN_BLANK_EN
            state_d = StBlank;
`else
            count_d  = count_inc;
            boundary = wrap;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        StBlank: begin
          if (timer_q == BlankLast) begin
            timer_d  = '0;
            state_d  = StDrive;
            count_d  = count_inc;
            boundary = wrap;
          end
        end
`endif
        default: begin
          state_d = StIdle;
          count_d = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next state so they are registered yet track the state.
  always_comb begin
    row_n_d = '1;
    for (int unsigned r = 0; r < ROW; r++) begin
      if (state_d == StDrive && count_d == BIT_COUNT'(r)) begin
        row_n_d[r] = 1'b0;
      end
    end
`ifdef SCAN_BLANK_EN
    blank_d = (state_d == StBlank);
`else
    blank_d = 1'b0;
`endif
  end

  // A frame accepted on the boundary edge lands in the shadow, never directly on display.
  always_comb begin
    capture   = frame_valid & ~full_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    full_d    = full_q;
    if (boundary && full_q) begin
      display_d = shadow_q;
      full_d    = 1'b0;
    end
    if (capture) begin
      shadow_d = frame_in;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      timer_q       <= '0;
      row_n_q       <= '1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      shadow_q      <= '0;
      display_q     <= '0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      row_n_q       <= row_n_d;
      blank_q       <= blank_d;
      frame_start_q <= boundary;
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      full_q        <= full_d;
    end
  end

  assign frame_ready    = ~full_q;
  assign display_matrix = display_q;
  assign count          = count_q;
  assign row_n          = row_n_q;
  assign blank          = blank_q;
  assign frame_start    = frame_start_q;

endmodule
